// File: rtl/ula_8bits_mestre.sv
// Command-side master for the combinational 8-bit ALU: registers one request onto the ALU
// inputs, waits LAT cycles, then queues the tagged, error-checked result in a response FIFO.
module ula_8bits_mestre #(
    parameter int LAT   = 1,
    parameter int DEPTH = 4,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [7:0]       cmd_A,
    input  logic [7:0]       cmd_B,
    input  logic [3:0]       cmd_Sel_Op,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [7:0]       A,
    output logic [7:0]       B,
    output logic [3:0]       Sel_Op,
    input  logic [15:0]      Resultado,
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [15:0]      resp_dado,
    output logic [TAG_W-1:0] resp_tag,
    output logic             resp_erro
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic [0:0] {
        OCIOSO = 1'b0,
        APLICA = 1'b1
    } estado_t;

    estado_t          state_r;
    estado_t          state_s;
    logic [3:0]       cnt_r;
    logic [TAG_W-1:0] tag_r;
    logic [PW-1:0]    wr_ptr_r;
    logic [PW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [15:0]      dado_mem [DEPTH];
    logic [TAG_W-1:0] tag_mem  [DEPTH];
    logic             erro_mem [DEPTH];
    logic             accept_s;
    logic             push_s;
    logic             pop_s;
    logic             erro_s;
    logic [15:0]      dado_s;

    // Divide/modulo by zero and unassigned opcodes are flagged; everything else is a legal result.
    function automatic logic op_erro(input logic [3:0] op, input logic [7:0] b);
        logic e;
        case (op)
            4'b0011, 4'b0100:                   e = (b == 8'd0);
            4'b0101, 4'b1101, 4'b1110, 4'b1111: e = 1'b1;
            default:                            e = 1'b0;
        endcase
        return e;
    endfunction

    assign cmd_ready  = (state_r == OCIOSO) && (count_r < DEPTH_C) && !rst;
    assign accept_s   = cmd_valid && cmd_ready;
    assign push_s     = (state_r == APLICA) && (cnt_r == 4'd0);
    assign resp_valid = (count_r != {CW{1'b0}});
    assign pop_s      = resp_valid && resp_ready;
    assign erro_s     = op_erro(Sel_Op, B);
    assign dado_s     = erro_s ? 16'd0 : Resultado;
    assign resp_dado  = dado_mem[rd_ptr_r];
    assign resp_tag   = tag_mem[rd_ptr_r];
    assign resp_erro  = erro_mem[rd_ptr_r];

    // Next-state logic for the request FSM.
    always_comb begin
        state_s = state_r;
        case (state_r)
            OCIOSO: begin
                if (accept_s) state_s = APLICA;
                else          state_s = OCIOSO;
            end
            APLICA: begin
                if (push_s) state_s = OCIOSO;
                else        state_s = APLICA;
            end
            default: state_s = OCIOSO;
        endcase
    end

    // FSM state, registered ALU operands and settle counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= OCIOSO;
            A       <= 8'd0;
            B       <= 8'd0;
            Sel_Op  <= 4'd0;
            tag_r   <= {TAG_W{1'b0}};
            cnt_r   <= 4'd0;
        end else begin
            state_r <= state_s;
            if (accept_s) begin
                A      <= cmd_A;
                B      <= cmd_B;
                Sel_Op <= cmd_Sel_Op;
                tag_r  <= cmd_tag;
                cnt_r  <= 4'(LAT - 1);
            end else if ((state_r == APLICA) && (cnt_r != 4'd0)) begin
                cnt_r <= cnt_r - 4'd1;
            end
        end
    end

    // Response storage; a result is written only when the settle time has elapsed.
    always_ff @(posedge clk) begin
        if (push_s && !rst) begin
            dado_mem[wr_ptr_r] <= dado_s;
            tag_mem[wr_ptr_r]  <= tag_r;
            erro_mem[wr_ptr_r] <= erro_s;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {PW{1'b0}};
            rd_ptr_r <= {PW{1'b0}};
            count_r  <= {CW{1'b0}};
        end else begin
            if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end
endmodule

// File: tb/tb_ula_8bits_mestre.sv
// Self-checking bench for ula_8bits_mestre: table vectors, hand-written corner sequences and
// randomized traffic checked every cycle against a queue-based transaction model.
module tb_ula_8bits_mestre;
    localparam int LAT   = 1;
    localparam int DEPTH = 4;
    localparam int TAG_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [7:0]       cmd_A = 8'd0;
    logic [7:0]       cmd_B = 8'd0;
    logic [3:0]       cmd_Sel_Op = 4'd0;
    logic [TAG_W-1:0] cmd_tag = '0;
    logic [7:0]       A;
    logic [7:0]       B;
    logic [3:0]       Sel_Op;
    logic [15:0]      Resultado;
    logic             resp_valid;
    logic             resp_ready = 1'b0;
    logic [15:0]      resp_dado;
    logic [TAG_W-1:0] resp_tag;
    logic             resp_erro;

    ula_8bits_mestre #(.LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_A(cmd_A), .cmd_B(cmd_B), .cmd_Sel_Op(cmd_Sel_Op), .cmd_tag(cmd_tag),
        .A(A), .B(B), .Sel_Op(Sel_Op), .Resultado(Resultado),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_dado(resp_dado), .resp_tag(resp_tag), .resp_erro(resp_erro)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the ALU; garbage on error cases so masking is visible.
    function automatic logic [15:0] alu_f(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
        int ia = a;
        int ib = b;
        int r;
        case (op)
            4'd0:  r = ia + ib;
            4'd1:  r = ia - ib;
            4'd2:  r = ia * ib;
            4'd3:  r = (ib == 0) ? 32'hFFFF : ia / ib;
            4'd4:  r = (ib == 0) ? 32'hFFFF : ia % ib;
            4'd6:  r = ia & ib;
            4'd7:  r = ia | ib;
            4'd8:  r = ia ^ ib;
            4'd9:  r = 255 - ia;
            4'd10: r = ia * 2;
            4'd11: r = ia / 2;
            4'd12: r = (ia > ib) ? 2 : ((ia < ib) ? 1 : 0);
            default: r = 32'hDEAD;
        endcase
        return r[15:0];
    endfunction

    always_comb Resultado = alu_f(A, B, Sel_Op);

    typedef struct {
        logic [15:0]      dado;
        logic [TAG_W-1:0] tag;
        logic             erro;
    } resp_t;

    function automatic resp_t expect_resp(input logic [7:0] a, input logic [7:0] b,
                                          input logic [3:0] op, input logic [TAG_W-1:0] t);
        resp_t r;
        r.erro = (((op == 4'd3) || (op == 4'd4)) && (b == 8'd0)) ||
                 (op == 4'd5) || (op == 4'd13) || (op == 4'd14) || (op == 4'd15);
        r.dado = r.erro ? 16'd0 : alu_f(a, b, op);
        r.tag  = t;
        return r;
    endfunction

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Transaction model: one request in flight, completed responses in a queue.
    bit          m_busy = 1'b0;
    int          m_left = 0;
    resp_t       m_pend;
    resp_t       m_fifo[$];
    logic [7:0]  m_a = 8'd0;
    logic [7:0]  m_b = 8'd0;
    logic [3:0]  m_op = 4'd0;
    resp_t       got[$];

    initial begin
        forever begin
            bit do_pop;
            bit do_acc;
            resp_t g;
            @(negedge clk);
            #1;
            chk("cmd_ready", 32'(cmd_ready), 32'(!m_busy && (m_fifo.size() < DEPTH) && !rst));
            chk("resp_valid", 32'(resp_valid), 32'(m_fifo.size() > 0));
            chk("alu_inputs", {12'd0, A, B, Sel_Op}, {12'd0, m_a, m_b, m_op});
            if (resp_valid && (m_fifo.size() > 0)) begin
                chk("head_dado", 32'(resp_dado), 32'(m_fifo[0].dado));
                chk("head_tag", 32'(resp_tag), 32'(m_fifo[0].tag));
                chk("head_erro", 32'(resp_erro), 32'(m_fifo[0].erro));
            end
            if (resp_valid && resp_ready && !rst) begin
                g.dado = resp_dado;
                g.tag  = resp_tag;
                g.erro = resp_erro;
                got.push_back(g);
            end
            @(posedge clk);
            if (rst) begin
                m_busy = 1'b0;
                m_fifo.delete();
                m_a = 8'd0;
                m_b = 8'd0;
                m_op = 4'd0;
            end else begin
                do_pop = resp_ready && (m_fifo.size() > 0);
                do_acc = cmd_valid && !m_busy && (m_fifo.size() < DEPTH);
                if (do_pop) void'(m_fifo.pop_front());
                if (m_busy) begin
                    m_left--;
                    if (m_left == 0) begin
                        m_fifo.push_back(m_pend);
                        m_busy = 1'b0;
                    end
                end else if (do_acc) begin
                    m_pend = expect_resp(cmd_A, cmd_B, cmd_Sel_Op, cmd_tag);
                    m_a = cmd_A;
                    m_b = cmd_B;
                    m_op = cmd_Sel_Op;
                    m_busy = 1'b1;
                    m_left = LAT;
                end
            end
        end
    end

    bit rnd_ready = 1'b0;

    task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op,
                         input logic [TAG_W-1:0] t, input int budget, output bit ok);
        int n = 0;
        ok = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_A = a;
        cmd_B = b;
        cmd_Sel_Op = op;
        cmd_tag = t;
        while (!ok && (n < budget)) begin
            if (rnd_ready) resp_ready = 1'($urandom_range(0, 1));
            #2;
            ok = cmd_ready;
            @(posedge clk);
            n++;
            if (!ok) @(negedge clk);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_A = 8'($urandom);
    endtask

    task automatic drain(input int n, input string nm);
        int c = 0;
        @(negedge clk);
        resp_ready = 1'b1;
        while ((got.size() < n) && (c < 60)) begin
            @(negedge clk);
            c++;
        end
        chk(nm, 32'(got.size() >= n), 32'd1);
    endtask

    typedef struct {
        logic [7:0]       a;
        logic [7:0]       b;
        logic [3:0]       op;
        logic [TAG_W-1:0] tag;
        logic [15:0]      dado;
        logic             erro;
    } vec_t;

    vec_t tbl[9];
    bit   ok;

    initial begin
        tbl[0] = '{8'd50,  8'd30, 4'b0000, 4'd1, 16'd80,  1'b0};
        tbl[1] = '{8'd3,   8'd90, 4'b0010, 4'd2, 16'd270, 1'b0};
        tbl[2] = '{8'd20,  8'd20, 4'b0010, 4'd3, 16'd400, 1'b0};
        tbl[3] = '{8'd100, 8'd0,  4'b0011, 4'd4, 16'd0,   1'b1};
        tbl[4] = '{8'd50,  8'd7,  4'b1110, 4'd5, 16'd0,   1'b1};
        tbl[5] = '{8'd23,  8'd5,  4'b0100, 4'd6, 16'd3,   1'b0};
        tbl[6] = '{8'd50,  8'd30, 4'b1100, 4'd7, 16'd2,   1'b0};
        tbl[7] = '{8'd20,  8'd80, 4'b1100, 4'd8, 16'd1,   1'b0};
        tbl[8] = '{8'd42,  8'd42, 4'b1100, 4'd9, 16'd0,   1'b0};

        repeat (3) @(negedge clk);
        #2;
        chk("reset_resp_valid", 32'(resp_valid), 32'd0);
        chk("reset_cmd_ready", 32'(cmd_ready), 32'd0);
        rst = 1'b0;

        // Latency: response visible one edge after the accepting edge.
        issue(8'd50, 8'd30, 4'b0000, 4'd1, 20, ok);
        chk("lat_accept", 32'(ok), 32'd1);
        chk("lat_not_yet", 32'(resp_valid), 32'd0);
        @(negedge clk);
        #2;
        chk("lat_valid", 32'(resp_valid), 32'd1);
        chk("lat_dado", 32'(resp_dado), 32'd80);
        got.delete();
        drain(1, "lat_drain");

        // Table vectors with the consumer always ready.
        got.delete();
        for (int i = 0; i < 9; i++) begin
            issue(tbl[i].a, tbl[i].b, tbl[i].op, tbl[i].tag, 20, ok);
            chk("tbl_accept", 32'(ok), 32'd1);
        end
        drain(9, "tbl_drain");
        for (int i = 0; i < 9 && i < got.size(); i++) begin
            chk("tbl_dado", 32'(got[i].dado), 32'(tbl[i].dado));
            chk("tbl_tag", 32'(got[i].tag), 32'(tbl[i].tag));
            chk("tbl_erro", 32'(got[i].erro), 32'(tbl[i].erro));
        end

        // Back-pressure: four requests fill the FIFO, the fifth waits for a pop.
        @(negedge clk);
        resp_ready = 1'b0;
        got.delete();
        for (int i = 0; i < 4; i++) begin
            issue(8'(10 + i), 8'd1, 4'b0000, 4'(i), 20, ok);
            chk("bp_accept", 32'(ok), 32'd1);
        end
        issue(8'd99, 8'd1, 4'b0000, 4'd4, 10, ok);
        chk("bp_fifth_blocked", 32'(ok), 32'd0);
        @(negedge clk);
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        issue(8'd99, 8'd1, 4'b0000, 4'd4, 10, ok);
        chk("bp_fifth_accept", 32'(ok), 32'd1);
        drain(5, "bp_drain");
        chk("bp_last_tag", 32'(got[got.size() - 1].tag), 32'd4);
        chk("bp_last_dado", 32'(got[got.size() - 1].dado), 32'd100);

        // Reset while a request is in flight with two entries queued.
        @(negedge clk);
        resp_ready = 1'b0;
        got.delete();
        issue(8'd1, 8'd1, 4'b0000, 4'd1, 20, ok);
        issue(8'd2, 8'd2, 4'b0000, 4'd2, 20, ok);
        issue(8'd3, 8'd3, 4'b0000, 4'd3, 20, ok);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #2;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        resp_ready = 1'b1;
        repeat (8) @(negedge clk);
        chk("rst_no_stale", 32'(got.size()), 32'd0);
        issue(8'd1, 8'd2, 4'b0000, 4'hA, 20, ok);
        drain(1, "rst_after_drain");
        chk("rst_after_dado", 32'(got[0].dado), 32'd3);
        chk("rst_after_tag", 32'(got[0].tag), 32'hA);

        // Randomized traffic checked by the model every cycle.
        rnd_ready = 1'b1;
        for (int i = 0; i < 150; i++) begin
            logic [7:0] rb;
            rb = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
            issue(8'($urandom), rb, 4'($urandom), 4'($urandom), 200, ok);
            chk("rand_accept", 32'(ok), 32'd1);
        end
        rnd_ready = 1'b0;
        @(negedge clk);
        resp_ready = 1'b1;
        for (int c = 0; c < 50 && (m_busy || m_fifo.size() > 0); c++) @(negedge clk);
        chk("rand_drained", 32'(m_busy || (m_fifo.size() > 0)), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
